// File: rtl/tpu_commit_agg.sv
// Commit aggregator: tracks threads dispatched to TPU subsets, routes per-TPU
// term/NACK pulses to the oldest waiting thread and issues in-order commits.
module tpu_commit_agg #(
  parameter int NUM_TPUS = 16,
  parameter int ID_WIDTH = 4,
  parameter int DEPTH    = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     I_Disp_Valid,
  input  logic [NUM_TPUS-1:0]      I_Disp_Mask,
  input  logic [ID_WIDTH-1:0]      I_Disp_ID,
  output logic                     O_Disp_Ready,
  input  logic [NUM_TPUS-1:0]      I_Term,
  input  logic [NUM_TPUS-1:0]      I_Nack,
  output logic                     O_Req_Commit,
  output logic [ID_WIDTH-1:0]      O_CommitNo,
  output logic                     O_Commit_Nack,
  input  logic                     I_Commit_Ack,
  output logic                     O_Busy,
  output logic [$clog2(DEPTH):0]   O_Count,
  output logic                     O_Err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_COMMIT} state_t;

  state_t                         state_q, state_d;
  logic [DEPTH-1:0]               valid_q;
  logic [DEPTH-1:0][ID_WIDTH-1:0] id_q;
  logic [DEPTH-1:0][NUM_TPUS-1:0] mask_q;
  logic [DEPTH-1:0][NUM_TPUS-1:0] done_q;
  logic [DEPTH-1:0]               nack_q;
  logic [PTR_W-1:0]               head_q, tail_q;
  logic [CNT_W-1:0]               count_q, count_d;
  logic                           req_q, req_d;
  logic [ID_WIDTH-1:0]            commit_no_q, commit_no_d;
  logic                           commit_nack_q, commit_nack_d;
  logic                           err_q;

  logic                           push, pop, head_cmp;
  logic [DEPTH-1:0]               tpu_hit [NUM_TPUS];
  logic [NUM_TPUS-1:0]            term_miss;
  logic [DEPTH-1:0][NUM_TPUS-1:0] ent_hit;

  assign O_Disp_Ready = (count_q < CNT_W'(DEPTH));
  assign push         = I_Disp_Valid && O_Disp_Ready;
  assign pop          = (state_q == S_COMMIT) && I_Commit_Ack;
  assign head_cmp     = valid_q[head_q] &&
                        ((done_q[head_q] & mask_q[head_q]) == mask_q[head_q]);
  assign count_d      = count_q + CNT_W'(push) - CNT_W'(pop);

  // Each TPU independently picks the oldest entry still waiting on it.
  for (genvar gi = 0; gi < NUM_TPUS; gi++) begin : g_route
    logic [DEPTH-1:0] hit;
    logic             found;
    always_comb begin
      logic [PTR_W-1:0] idx;
      hit   = '0;
      found = 1'b0;
      idx   = head_q;
      for (int k = 0; k < DEPTH; k++) begin
        idx = head_q + PTR_W'(k);
        if (!found && valid_q[idx] && mask_q[idx][gi] && !done_q[idx][gi]) begin
          found    = 1'b1;
          hit[idx] = I_Term[gi];
        end
      end
    end
    assign tpu_hit[gi]   = hit;
    assign term_miss[gi] = I_Term[gi] && !found;
  end

  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      for (int t = 0; t < NUM_TPUS; t++) begin
        ent_hit[e][t] = tpu_hit[t][e];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      id_q    <= '0;
      mask_q  <= '0;
      done_q  <= '0;
      nack_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        done_q[e] <= done_q[e] | ent_hit[e];
        nack_q[e] <= nack_q[e] | (|(ent_hit[e] & I_Nack));
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      // The tail slot is never a term target, so the fresh write wins cleanly.
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        id_q[tail_q]    <= I_Disp_ID;
        mask_q[tail_q]  <= I_Disp_Mask;
        done_q[tail_q]  <= '0;
        nack_q[tail_q]  <= 1'b0;
        tail_q          <= tail_q + PTR_W'(1);
      end
      count_q <= count_d;
      err_q   <= err_q | (|term_miss);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      req_q         <= 1'b0;
      commit_no_q   <= '0;
      commit_nack_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      commit_no_q   <= commit_no_d;
      commit_nack_q <= commit_nack_d;
    end
  end

  // Stay in TRACK when an entry lands as the queue drains, else it would stall.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (push) state_d = S_TRACK;
      S_TRACK: begin
        if (head_cmp)                           state_d = S_COMMIT;
        else if ((count_q == '0) && !push)      state_d = S_IDLE;
      end
      S_COMMIT: begin
        if (I_Commit_Ack)
          state_d = ((count_q == CNT_W'(1)) && !push) ? S_IDLE : S_TRACK;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_d         = req_q;
    commit_no_d   = commit_no_q;
    commit_nack_d = commit_nack_q;
    case (state_q)
      S_TRACK: begin
        if (head_cmp) begin
          req_d         = 1'b1;
          commit_no_d   = id_q[head_q];
          commit_nack_d = nack_q[head_q];
        end
      end
      S_COMMIT: if (I_Commit_Ack) req_d = 1'b0;
      default: ;
    endcase
  end

  assign O_Req_Commit  = req_q;
  assign O_CommitNo    = commit_no_q;
  assign O_Commit_Nack = commit_nack_q;
  assign O_Busy        = (count_q != '0);
  assign O_Count       = count_q;
  assign O_Err         = err_q;

endmodule

// File: tb/tb_tpu_commit_agg.sv
// Bench for tpu_commit_agg: directed scenarios plus random traffic checked
// against a queue-based model of outstanding threads.
module tb_tpu_commit_agg;

  localparam int NT = 16;
  localparam int IW = 4;
  localparam int DP = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          dv;
  logic [NT-1:0] dmask;
  logic [IW-1:0] did;
  logic          ready;
  logic [NT-1:0] term;
  logic [NT-1:0] nack;
  logic          req;
  logic [IW-1:0] commit_no;
  logic          commit_nack;
  logic          ack;
  logic          busy;
  logic [3:0]    count;
  logic          err;

  always #5 clk = ~clk;

  tpu_commit_agg #(.NUM_TPUS(NT), .ID_WIDTH(IW), .DEPTH(DP)) dut (
    .clock(clk), .reset(rst),
    .I_Disp_Valid(dv), .I_Disp_Mask(dmask), .I_Disp_ID(did), .O_Disp_Ready(ready),
    .I_Term(term), .I_Nack(nack),
    .O_Req_Commit(req), .O_CommitNo(commit_no), .O_Commit_Nack(commit_nack),
    .I_Commit_Ack(ack), .O_Busy(busy), .O_Count(count), .O_Err(err)
  );

  typedef struct packed {
    logic [IW-1:0] id;
    logic [NT-1:0] mask;
    logic [NT-1:0] done;
    logic          nack;
  } ent_t;

  ent_t          mq[$];
  logic          m_err = 1'b0;
  logic          prev_pop = 1'b0;
  logic          prev_hold = 1'b0;
  logic [IW-1:0] prev_no = '0;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit ent_done(input ent_t e);
    return (e.done & e.mask) == e.mask;
  endfunction

  function automatic bit has_target(input int i);
    for (int j = 0; j < mq.size(); j++)
      if (mq[j].mask[i] && !mq[j].done[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Check current outputs against the model, advance the model, then clock.
  task automatic step();
    int   sz;
    bit   do_pop;
    bit   found;
    ent_t e;
    sz = mq.size();
    chk("count", 32'(count), 32'(sz));
    chk("busy", 32'(busy), 32'(sz != 0));
    chk("ready", 32'(ready), 32'(sz < DP));
    chk("err", 32'(err), 32'(m_err));
    if (req) begin
      if (sz == 0) chk("req_empty", 32'(req), 32'(0));
      else begin
        chk("commit_no", 32'(commit_no), 32'(mq[0].id));
        chk("commit_nack", 32'(commit_nack), 32'(mq[0].nack));
        chk("head_complete", 32'(ent_done(mq[0])), 32'(1));
      end
    end
    if (prev_pop) chk("req_gap", 32'(req), 32'(0));
    if (prev_hold) begin
      chk("req_hold", 32'(req), 32'(1));
      chk("hold_no", 32'(commit_no), 32'(prev_no));
    end
    if (rst) begin
      mq.delete();
      m_err     = 1'b0;
      prev_pop  = 1'b0;
      prev_hold = 1'b0;
    end else begin
      do_pop = req && ack && (sz > 0);
      for (int i = 0; i < NT; i++) begin
        if (term[i]) begin
          found = 1'b0;
          for (int j = 0; j < mq.size(); j++) begin
            if (!found && mq[j].mask[i] && !mq[j].done[i]) begin
              e = mq[j];
              e.done[i] = 1'b1;
              e.nack = e.nack | nack[i];
              mq[j] = e;
              found = 1'b1;
            end
          end
          if (!found) m_err = 1'b1;
        end
      end
      prev_pop  = req && ack;
      prev_hold = req && !ack;
      prev_no   = commit_no;
      if (do_pop) begin
        $display("commit id=%0d nack=%0d", mq[0].id, mq[0].nack);
        void'(mq.pop_front());
      end
      if (dv && sz < DP) begin
        e.id = did; e.mask = dmask; e.done = '0; e.nack = 1'b0;
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    dv   = 1'b0;
    term = '0;
    nack = '0;
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!req && n < 64) begin
      step();
      n++;
    end
    chk(tag, 32'(req), 32'(1));
  endtask

  task automatic disp(input logic [IW-1:0] id, input logic [NT-1:0] m);
    dv = 1'b1; did = id; dmask = m;
    step();
  endtask

  task automatic commit_one(input string tag, input logic [IW-1:0] id);
    wait_req({tag, "_req"});
    chk({tag, "_id"}, 32'(commit_no), 32'(id));
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  initial begin
    int nid;
    int acks;
    rst = 1'b1; dv = 1'b0; dmask = '0; did = '0; term = '0; nack = '0; ack = 1'b0;
    @(posedge clk); #1;
    step();
    rst = 1'b0;
    chk("rst_req", 32'(req), 32'(0));
    chk("rst_ready", 32'(ready), 32'(1));
    chk("rst_count", 32'(count), 32'(0));

    // Basic latency: last term at cycle 12 -> request at cycle 14
    disp(4'd3, 16'h0005);
    repeat (9) step();
    term = 16'h0001; step();
    step();
    term = 16'h0004; step();
    chk("basic_c13_req", 32'(req), 32'(0));
    step();
    chk("basic_c14_req", 32'(req), 32'(1));
    chk("basic_id", 32'(commit_no), 32'(3));
    chk("basic_nack", 32'(commit_nack), 32'(0));
    step(); step();
    ack = 1'b1; step(); ack = 1'b0;
    chk("basic_c17_req", 32'(req), 32'(0));
    chk("basic_count", 32'(count), 32'(0));
    chk("basic_busy", 32'(busy), 32'(0));

    // NACK
    disp(4'd7, 16'h0003);
    term = 16'h0003; nack = 16'h0002; step();
    wait_req("nack_req");
    chk("nack_id", 32'(commit_no), 32'(7));
    chk("nack_flag", 32'(commit_nack), 32'(1));
    ack = 1'b1; step(); ack = 1'b0;

    // Ordering: younger complete entry waits behind the head
    disp(4'd1, 16'h0001);
    disp(4'd2, 16'h0002);
    term = 16'h0002; step();
    repeat (4) step();
    chk("order_blocked", 32'(req), 32'(0));
    term = 16'h0001; step();
    commit_one("order1", 4'd1);
    chk("order_gap", 32'(req), 32'(0));
    commit_one("order2", 4'd2);

    // Per-TPU in-order routing
    disp(4'd4, 16'h0001);
    disp(4'd5, 16'h0001);
    term = 16'h0001; step();
    step();
    term = 16'h0001; step();
    commit_one("route4", 4'd4);
    commit_one("route5", 4'd5);
    chk("route_err", 32'(err), 32'(0));

    // Full and wrap-around
    for (int k = 0; k < DP; k++) disp(IW'(k), '0);
    chk("full_ready", 32'(ready), 32'(0));
    chk("full_count", 32'(count), 32'(8));
    disp(4'd9, '0);
    chk("full_drop", 32'(count), 32'(8));
    nid = 8; acks = 0; ack = 1'b1;
    for (int c = 0; c < 80 && acks < 16; c++) begin
      if (req) acks++;
      if (nid < 16 && ready) begin
        dv = 1'b1; did = IW'(nid); dmask = '0; nid++;
      end
      step();
    end
    ack = 1'b0;
    chk("wrap_acks", 32'(acks), 32'(16));
    chk("wrap_count", 32'(count), 32'(0));

    // Error is sticky; reset mid-request clears everything
    term = 16'h8000; step();
    chk("err_set", 32'(err), 32'(1));
    repeat (3) step();
    chk("err_sticky", 32'(err), 32'(1));
    disp(4'd11, '0);
    wait_req("rst_mid_req");
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_mid_req0", 32'(req), 32'(0));
    chk("rst_mid_err", 32'(err), 32'(0));
    chk("rst_mid_count", 32'(count), 32'(0));
    chk("rst_mid_ready", 32'(ready), 32'(1));

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(2) == 0) begin
        dv = 1'b1;
        did = IW'($urandom);
        dmask = NT'($urandom & $urandom);
        if ($urandom_range(7) == 0) dmask = '0;
      end
      for (int i = 0; i < NT; i++) begin
        if (has_target(i) && $urandom_range(3) == 0) begin
          term[i] = 1'b1;
          nack[i] = ($urandom_range(7) == 0);
        end
      end
      ack = ($urandom_range(1) == 1);
      step();
    end
    ack = 1'b0;
    chk("rand_err", 32'(err), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tpu_commit_agg.md
Name: tpu_commit_agg

Overview:
- Sits between the TPU array and the MPU commit port.
- Tracks every thread the MPU dispatches to a subset of TPUs, identified by a commit number and a participation mask.
- Collects per-TPU termination and NACK pulses, then issues in-order commit requests (I_Req_Commit / I_CommitNo on the MPU side) with a valid/ack handshake.

Parameters:
NUM_TPUS, 16, number of TPUs (TPU_ROWS*TPU_CLMS); width of masks and term/nack vectors
ID_WIDTH, 4, width of commit number
DEPTH, 8, max outstanding threads (power of two, >=2)

Ports:
clock  in  1  system clock
reset  in  1  reset
I_Disp_Valid  in  1  MPU dispatches a thread this cycle
I_Disp_Mask  in  NUM_TPUS  participating TPUs
I_Disp_ID  in  ID_WIDTH  commit number of dispatched thread
O_Disp_Ready  out  1  entry available
I_Term  in  NUM_TPUS  per-TPU one-cycle termination pulse
I_Nack  in  NUM_TPUS  per-TPU NACK, qualified by the same-bit I_Term
O_Req_Commit  out  1  commit request to MPU
O_CommitNo  out  ID_WIDTH  commit number being committed
O_Commit_Nack  out  1  at least one participant NACKed
I_Commit_Ack  in  1  MPU accepts commit
O_Busy  out  1  at least one entry outstanding
O_Count  out  $clog2(DEPTH)+1  outstanding entries
O_Err  out  1  sticky: term with no matching entry

Behaviour:
- Reset is synchronous and active-high on clock.
  - Clears all entries, head, tail, count, FSM and O_Err.
  - All outputs read 0 in the cycle after reset is sampled, except O_Disp_Ready=1.
  - Reset mid-operation drops O_Req_Commit with no ack needed; pending entries are discarded.
- Entry fields: valid, id, mask, done[NUM_TPUS], nack. Storage is a circular buffer with head/tail wrapping modulo DEPTH.
- Dispatch:
  - O_Disp_Ready = (count < DEPTH), combinational from registered count.
  - I_Disp_Valid && O_Disp_Ready writes the tail entry at the edge: done=0, nack=0.
  - Dispatch while full is ignored; a pop in the same cycle does not free space for it.
- Term routing, per TPU bit i when I_Term[i]=1:
  - Target is the oldest valid entry (searching from head) with mask[i]=1 and done[i]=0.
  - Sets done[i]; ORs I_Nack[i] into that entry's nack.
  - No target sets O_Err (sticky until reset). This includes a term arriving in the same cycle as its own dispatch.
  - Multiple TPU bits in one cycle are handled independently, in parallel.
- An entry is complete when (done & mask) == mask. A mask of 0 is complete on write.
- FSM:
  - IDLE: count==0. Go to TRACK at the first dispatch.
  - TRACK: if the head entry is complete, register O_Req_Commit=1, O_CommitNo=head.id, O_Commit_Nack=head.nack, then go to COMMIT. If count==0, go to IDLE.
  - COMMIT: hold all request outputs stable until I_Commit_Ack.
    - On ack: pop head (head++, count--) and deassert O_Req_Commit next cycle.
    - Then go to TRACK, or to IDLE if count becomes 0 with no dispatch that cycle.
  - I_Commit_Ack is ignored while O_Req_Commit=0.
- Latency:
  - Last required term at cycle N gives O_Req_Commit=1 at cycle N+2 (provided it is at head and the FSM is in TRACK).
  - Minimum one-cycle gap of O_Req_Commit=0 between back-to-back commits.
- Commits are strictly in dispatch order. A younger complete entry waits behind an incomplete head.
- A term to a non-head entry during COMMIT is accepted normally. The head entry is never targeted, since it is already complete.
- count update with simultaneous push and pop: count unchanged; write at tail, head advances.
- O_Busy = (count != 0). O_Count = count (registered).

Test Plan:
- Basic: dispatch ID=3 mask=0x0005; I_Term=0x0001 at cycle 10, 0x0004 at cycle 12 -> O_Req_Commit=1 at cycle 14, CommitNo=3, Commit_Nack=0; ack at cycle 16 -> Req=0 at cycle 17, Count=0, Busy=0.
- NACK: dispatch ID=7 mask=0x0003; I_Term=0x0003 with I_Nack=0x0002 -> commit with CommitNo=7, Commit_Nack=1.
- Ordering: dispatch ID=1 mask=0x1, then ID=2 mask=0x2; term TPU1 first, then TPU0 five cycles later -> commits ID=1 then ID=2, with >=1 idle cycle between requests.
- Per-TPU in-order routing: dispatch ID=4 and ID=5, both mask=0x1; two I_Term[0] pulses -> the first completes ID=4, the second completes ID=5; O_Err=0.
- Full / wrap-around:
  - Issue 8 dispatches with mask=0, holding ack low -> O_Disp_Ready=0 and Count=8; a 9th dispatch is dropped.
  - Ack 8 times while dispatching 8 more -> CommitNo sequence matches dispatch order across pointer wrap.
- Error and reset: I_Term=0x8000 with nothing outstanding -> O_Err=1 and stays 1; reset asserted while O_Req_Commit=1 -> next cycle Req=0, Err=0, Count=0, Disp_Ready=1.
